// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in E.
// Optional DIV_ZERO_FAST_EN: divide-by-zero finishes one cycle after launch.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             div_annulE,
  output logic             stall_divE,
  output logic             div_readyE,
  output logic [WIDTH-1:0] div_hiE,
  output logic [WIDTH-1:0] div_loE,
  output logic             div_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             qs;
  logic             rs;
  logic [WIDTH-1:0] hiQ;
  logic [WIDTH-1:0] loQ;

  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] loFinal;
  logic [WIDTH-1:0] hiFinal;

  // Operand magnitudes and one restoring iteration; the extra shifted bit
  // keeps the compare exact when the divisor has its MSB set.
  always_comb begin
    sa      = div_signedE & srcaE[WIDTH-1];
    sb      = div_signedE & srcbE[WIDTH-1];
    magA    = sa ? (~srcaE + 1'b1) : srcaE;
    magB    = sb ? (~srcbE + 1'b1) : srcbE;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    fits    = shifted >= {1'b0, dvsr};
    remNext = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quoNext = {quo[WIDTH-2:0], fits};
    loFinal = qs ? (~quoNext + 1'b1) : quoNext;
    hiFinal = rs ? (~remNext + 1'b1) : remNext;
  end

  // Sequencer: launch in IDLE, one quotient bit per RUN cycle, result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      qs      <= 1'b0;
      rs      <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
    end else if (div_annulE) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_startE) begin
            rem     <= '0;
            quo     <= magA;
            dvsr    <= magB;
            qs      <= sa ^ sb;
            rs      <= sa;
            counter <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (magB == '0) begin
              loQ   <= (sa ^ sb) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
              hiQ   <= srcaE;
              state <= DONE;
            end else begin
              state <= RUN;
            end
`else
            state   <= RUN;
`endif
          end
        end
        RUN: begin
          rem     <= remNext;
          quo     <= quoNext;
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            hiQ   <= hiFinal;
            loQ   <= loFinal;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall_divE = div_startE & ~div_annulE & (state != DONE);
  assign div_readyE = (state == DONE) & ~div_annulE;
  assign div_hiE    = hiQ;
  assign div_loE    = loQ;
  assign div_busy   = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer.
// Expected results are queued at launch and popped on div_readyE.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         startE = 1'b0;
  logic         signedE = 1'b0;
  logic         annulE = 1'b0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic         stallE;
  logic         readyE;
  logic [W-1:0] hiE;
  logic [W-1:0] loE;
  logic         busy;

  div_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_startE  (startE),
    .div_signedE (signedE),
    .srcaE       (srcA),
    .srcbE       (srcB),
    .div_annulE  (annulE),
    .stall_divE  (stallE),
    .div_readyE  (readyE),
    .div_hiE     (hiE),
    .div_loE     (loE),
    .div_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           stalls;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y, input bit s);
    exp_t e;
    bit nx, ny;
    logic [W-1:0] mx, my, q, r;
    nx = s && x[W-1];
    ny = s && y[W-1];
    mx = nx ? -x : x;
    my = ny ? -y : y;
    q = (my == 0) ? '1 : mx / my;
    r = (my == 0) ? mx : mx % my;
    e.lo = (nx ^ ny) ? -q : q;
    e.hi = nx ? -r : r;
`ifdef DIV_ZERO_FAST_EN
    e.stalls = (y == 0) ? 1 : W + 1;
`else
    e.stalls = W + 1;
`endif
    return e;
  endfunction

  task automatic runDiv(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit s);
    int cyc;
    int stalls;
    bit got;
    exp_t p;
    sbq.push_back(model(x, y, s));
    startE = 1'b1;
    signedE = s;
    srcA = x;
    srcB = y;
    cyc = 0;
    stalls = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "/idle_rdy"}, W'(readyE), '0);
      if (cyc == 3) begin
        srcA = $urandom;
        srcB = $urandom;
      end
      if (stallE) stalls++;
      if (readyE) got = 1'b1;
    end
    chk({tag, "/ready_seen"}, W'(got), W'(1));
    if (got && sbq.size() > 0) begin
      p = sbq.pop_front();
      chk({tag, "/stalls"}, W'(stalls), W'(p.stalls));
      chk({tag, "/lo"}, loE, p.lo);
      chk({tag, "/hi"}, hiE, p.hi);
    end
    @(posedge clk);
    #1;
    startE = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", W'(busy), '0);
    chk("rst/ready", W'(readyE), '0);
    chk("rst/stall", W'(stallE), '0);
    chk("rst/hi", hiE, '0);
    chk("rst/lo", loE, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    runDiv("divu7_2", 32'd7, 32'd2, 1'b0);
    chk("divu7_2/lo_const", loE, 32'h3);
    runDiv("divm7_2", 32'hFFFFFFF9, 32'd2, 1'b1);
    chk("divm7_2/lo_const", loE, 32'hFFFFFFFD);
    chk("divm7_2/hi_const", hiE, 32'hFFFFFFFF);
    runDiv("div7_m2", 32'd7, 32'hFFFFFFFE, 1'b1);
    runDiv("divu_ff_10", 32'hFFFFFFFF, 32'h10, 1'b0);
    chk("divu_ff_10/lo_const", loE, 32'h0FFFFFFF);
    runDiv("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1);
    chk("ovf/lo_const", loE, 32'h80000000);
    runDiv("divu_big", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    runDiv("divu5_0", 32'd5, 32'd0, 1'b0);
    chk("divu5_0/lo_const", loE, 32'hFFFFFFFF);
    runDiv("divm5_0", 32'hFFFFFFFB, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      runDiv($sformatf("rnd%0d", i), $urandom, $urandom_range(1, 1000),
             bit'(i[0]));
    end

    // annul mid-RUN
    startE = 1'b1;
    signedE = 1'b0;
    srcA = 32'd100;
    srcB = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    annulE = 1'b1;
    @(negedge clk);
    chk("annul/stall", W'(stallE), '0);
    chk("annul/ready", W'(readyE), '0);
    @(posedge clk);
    #1;
    annulE = 1'b0;
    startE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("annul/idle_busy", W'(busy), '0);
      chk("annul/no_ready", W'(readyE), '0);
    end
    @(posedge clk);
    #1;
    runDiv("after_annul", 32'd100, 32'd3, 1'b0);

    // back-to-back, then reset in the second
    runDiv("b2b1", 32'd1000, 32'd7, 1'b0);
    sbq.push_back(model(32'd50, 32'd5, 1'b0));
    startE = 1'b1;
    signedE = 1'b0;
    srcA = 32'd50;
    srcB = 32'd5;
    @(posedge clk);
    @(negedge clk);
    chk("b2b2/launched", W'(busy), W'(1));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    startE = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sbq.pop_back());
    @(negedge clk);
    chk("rstmid/busy", W'(busy), '0);
    chk("rstmid/hi", hiE, '0);
    chk("rstmid/lo", loE, '0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rstmid/no_ready", W'(readyE), '0);
    end

    chk("sb/empty", W'(sbq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
